// File: rtl/sub_pipe_pkg.sv
// Shared arithmetic helpers for the parametrised pipelined subtractor.
// Functions work on a generic wide signed type; callers slice to their own widths.
package sub_pipe_pkg;

  localparam int MAX_W = 32;

  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic int fw_of(input int in_w);
    return in_w + 1;
  endfunction

  function automatic wide_t clamp_hi(input int out_w);
    return wide_t'((1 << (out_w - 1)) - 1);
  endfunction

  function automatic wide_t clamp_lo(input int out_w);
    return wide_t'(-(1 << (out_w - 1)));
  endfunction

  // Only the low in_w bits of value are meaningful; the rest are rebuilt here.
  function automatic wide_t ext_op(input wide_t value, input int in_w, input bit signed_mode);
    int shift;
    shift = MAX_W - in_w;
    if (signed_mode) begin
      return (value <<< shift) >>> shift;
    end
    return wide_t'($unsigned(value << shift) >> shift);
  endfunction

  // Returns {overflow_flag, result}; the caller keeps result[out_w-1:0].
  function automatic logic [MAX_W:0] fit_out(input wide_t d, input int out_w, input int fw,
                                             input bit sat);
    wide_t hi;
    wide_t lo;
    wide_t res;
    logic  flag;
    hi   = clamp_hi(out_w);
    lo   = clamp_lo(out_w);
    res  = d;
    flag = 1'b0;
    if (out_w < fw) begin
      if (d > hi) begin
        flag = 1'b1;
        if (sat) res = hi;
      end else if (d < lo) begin
        flag = 1'b1;
        if (sat) res = lo;
      end
    end
    return {flag, res};
  endfunction

endpackage

// File: rtl/sub_pipe_param_stage.sv
// One pipeline slot: valid bit, data word and overflow flag, advanced by a global enable.
// Flush drops the valid bit only; the data word may keep a stale value.
module sub_pipe_stage #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         flag_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         flag_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         flag_q, flag_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;
    if (adv_i) begin
      valid_d = valid_i;
      data_d  = data_i;
      flag_d  = flag_i;
    end
    if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/sub_pipe_param.sv
// Pipelined aIn - bIn with width conversion, overflow flag and valid/ready flow control.
// The whole pipe stalls together when the last stage holds an unconsumed result.
module sub_pipe_param
  import sub_pipe_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 5,
  parameter int LAT       = 3,
  parameter int SIGNED_IN = 0,
  parameter int SAT       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [IN_W-1:0]  aIn,
  input  logic        [IN_W-1:0]  bIn,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] subOut,
  output logic                    satOut
);

  localparam int FW = fw_of(IN_W);

  wide_t            aExt;
  wide_t            bExt;
  wide_t            diffW;
  logic [MAX_W:0]   fitRes;
  logic [MAX_W-1:OUT_W] unusedFitBits;
  logic             adv;

  logic [LAT:0]     vChain;
  logic [LAT:0]     fChain;
  logic [OUT_W-1:0] dChain [LAT+1];

  // FW-bit difference cannot overflow, so the wide type holds it exactly.
  always_comb begin
    aExt   = ext_op(wide_t'(aIn), IN_W, SIGNED_IN != 0);
    bExt   = ext_op(wide_t'(bIn), IN_W, SIGNED_IN != 0);
    diffW  = aExt - bExt;
    fitRes = fit_out(diffW, OUT_W, FW, SAT != 0);
  end

  assign unusedFitBits = fitRes[MAX_W-1:OUT_W];

  assign adv      = ~vChain[LAT] | out_ready;
  assign in_ready = rst_n & adv & ~clr;

  assign vChain[0] = in_valid & in_ready;
  assign dChain[0] = fitRes[OUT_W-1:0];
  assign fChain[0] = fitRes[MAX_W];

  for (genvar s = 1; s <= LAT; s++) begin : gStage
    sub_pipe_stage #(
      .W(OUT_W)
    ) uStage (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr),
      .adv_i  (adv),
      .valid_i(vChain[s-1]),
      .data_i (dChain[s-1]),
      .flag_i (fChain[s-1]),
      .valid_o(vChain[s]),
      .data_o (dChain[s]),
      .flag_o (fChain[s])
    );
  end

  assign out_valid = vChain[LAT];
  assign subOut    = dChain[LAT];
  assign satOut    = fChain[LAT];

endmodule

// File: tb/tb_sub_pipe_param.sv
// Four configurations share one stimulus stream; a queue of arithmetic expectations
// is checked whenever a result is presented.
module tb_sub_pipe_param;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic inValid;
  logic outReady;
  logic [3:0] aIn;
  logic [3:0] bIn;

  logic inRdy [4];
  logic outV  [4];
  logic satO  [4];
  logic [4:0] sub0;
  logic [3:0] sub1;
  logic [3:0] sub2;
  logic [4:0] sub3;

  int checks = 0;
  int errors = 0;

  logic [3:0][5:0] expQ [$];

  always #5 clk = ~clk;

  sub_pipe_param #(.IN_W(4), .OUT_W(5), .LAT(3), .SIGNED_IN(0), .SAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(inRdy[0]),
    .aIn(aIn), .bIn(bIn), .out_valid(outV[0]), .out_ready(outReady),
    .subOut(sub0), .satOut(satO[0]));

  sub_pipe_param #(.IN_W(4), .OUT_W(4), .LAT(3), .SIGNED_IN(0), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(inRdy[1]),
    .aIn(aIn), .bIn(bIn), .out_valid(outV[1]), .out_ready(outReady),
    .subOut(sub1), .satOut(satO[1]));

  sub_pipe_param #(.IN_W(4), .OUT_W(4), .LAT(3), .SIGNED_IN(0), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(inRdy[2]),
    .aIn(aIn), .bIn(bIn), .out_valid(outV[2]), .out_ready(outReady),
    .subOut(sub2), .satOut(satO[2]));

  sub_pipe_param #(.IN_W(4), .OUT_W(5), .LAT(3), .SIGNED_IN(1), .SAT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(inRdy[3]),
    .aIn(aIn), .bIn(bIn), .out_valid(outV[3]), .out_ready(outReady),
    .subOut(sub3), .satOut(satO[3]));

  // Plain integer arithmetic: returns {overflow, 5-bit two's-complement result}.
  function automatic logic [5:0] refModel(input int a, input int b, input int outW,
                                          input bit sgn, input bit sat);
    int ai, bi, d, hi, lo, r;
    bit f;
    ai = (sgn && a >= 8) ? a - 16 : a;
    bi = (sgn && b >= 8) ? b - 16 : b;
    d  = ai - bi;
    hi = (2 ** (outW - 1)) - 1;
    lo = -(2 ** (outW - 1));
    r  = d;
    f  = 1'b0;
    if (outW < 5 && (d > hi || d < lo)) begin
      f = 1'b1;
      if (sat) r = (d > hi) ? hi : lo;
    end
    return {f, 5'(r)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; drives one cycle, checks, and returns at the next falling edge.
  task automatic applyStimulus(input bit iv, input int a, input int b, input bit ordy,
                               input bit cl);
    logic [3:0][5:0] e;
    logic [3:0][5:0] f;
    bit acc, cons, expRdy;
    inValid  = iv;
    aIn      = 4'(a);
    bIn      = 4'(b);
    outReady = ordy;
    clr      = cl;
    #1;
    expRdy = (!outV[0] || ordy) && !cl;
    checkOutput("inReady0", 32'(inRdy[0]), 32'(expRdy));
    checkOutput("inReady3", 32'(inRdy[3]), 32'(expRdy));
    if (outV[0] || outV[1] || outV[2] || outV[3]) begin
      checkOutput("occupancy", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        f = expQ[0];
        checkOutput("sub0", 32'(sub0), 32'(f[0][4:0]));
        checkOutput("sat0", 32'(satO[0]), 32'(f[0][5]));
        checkOutput("sub1", 32'(sub1), 32'(f[1][3:0]));
        checkOutput("sat1", 32'(satO[1]), 32'(f[1][5]));
        checkOutput("sub2", 32'(sub2), 32'(f[2][3:0]));
        checkOutput("sat2", 32'(satO[2]), 32'(f[2][5]));
        checkOutput("sub3", 32'(sub3), 32'(f[3][4:0]));
        checkOutput("sat3", 32'(satO[3]), 32'(f[3][5]));
      end
    end
    acc  = iv && inRdy[0];
    cons = outV[0] && ordy;
    e[0] = refModel(a, b, 5, 1'b0, 1'b1);
    e[1] = refModel(a, b, 4, 1'b0, 1'b1);
    e[2] = refModel(a, b, 4, 1'b0, 1'b0);
    e[3] = refModel(a, b, 5, 1'b1, 1'b1);
    @(posedge clk);
    if (cons && expQ.size() > 0) void'(expQ.pop_front());
    if (cl) expQ.delete();
    if (acc && !cl) expQ.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; inValid = 1'b0; outReady = 1'b1; aIn = '0; bIn = '0;
    #1;
    checkOutput("rstOutValid", 32'(outV[0]), 32'd0);
    checkOutput("rstSubOut", 32'(sub0), 32'd0);
    checkOutput("rstSatOut", 32'(satO[0]), 32'd0);
    checkOutput("rstInReady", 32'(inRdy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single transaction latency: 3 - 7 = -4.
    applyStimulus(1, 3, 7, 1, 0);
    checkOutput("lat1", 32'(outV[0]), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lat2", 32'(outV[0]), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lat3Valid", 32'(outV[0]), 32'd1);
    checkOutput("lat3Sub", 32'(sub0), 32'h1C);
    checkOutput("lat3Sat", 32'(satO[0]), 32'd0);

    // Back-to-back boundary pairs across all configurations.
    applyStimulus(1, 15, 0, 1, 0);
    applyStimulus(1, 0, 15, 1, 0);
    applyStimulus(1, 9, 9, 1, 0);
    checkOutput("b2bValid0", 32'(outV[0]), 32'd1);
    checkOutput("b2bSub15", 32'(sub0), 32'h0F);
    checkOutput("clampHi", 32'({satO[1], sub1}), 32'h17);
    checkOutput("wrapHi", 32'({satO[2], sub2}), 32'h1F);
    checkOutput("signedNeg1", 32'(sub3), 32'h1F);
    applyStimulus(1, 8, 7, 1, 0);
    checkOutput("b2bValid1", 32'(outV[0]), 32'd1);
    checkOutput("b2bSubM15", 32'(sub0), 32'h11);
    checkOutput("clampLo", 32'({satO[1], sub1}), 32'h18);
    checkOutput("wrapLo", 32'({satO[2], sub2}), 32'h11);
    checkOutput("signedPos1", 32'(sub3), 32'h01);
    applyStimulus(1, 7, 8, 1, 0);
    checkOutput("b2bValid2", 32'(outV[0]), 32'd1);
    checkOutput("b2bSub0", 32'(sub0), 32'h00);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("signedM15", 32'(sub3), 32'h11);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("signedP15", 32'(sub3), 32'h0F);
    applyStimulus(0, 0, 0, 1, 0);

    // Stall a full pipe for four cycles, then let it stream out.
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 12, 5, 0, 0);
      checkOutput("stallHold", 32'(outV[0]), 32'd1);
    end
    applyStimulus(1, 12, 5, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("stallDrained", expQ.size(), 32'd0);

    // Flush with three results in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1, i + 4, 1, 1, 0);
    applyStimulus(1, 2, 2, 1, 1);
    checkOutput("clrValid", 32'(outV[0]), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("clrStaysEmpty", 32'(outV[0]), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1, 9, i, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(outV[0]), 32'd0);
    checkOutput("midRstSub", 32'(sub0), 32'd0);
    checkOutput("midRstReady", 32'(inRdy[0]), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 5, 2, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("postRstEarly", 32'(outV[0]), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("postRstValid", 32'(outV[0]), 32'd1);
    checkOutput("postRstSub", 32'(sub0), 32'd3);

    // Random traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 80; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 20 && expQ.size() > 0; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("finalDrained", expQ.size(), 32'd0);
    checkOutput("finalIdle", 32'(outV[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_pipe_param.md
Name: sub_pipe_param

Overview:
- Parametrised pipelined subtractor: computes aIn - bIn with configurable input width, output width, signedness, latency and overflow policy.
- Adds a valid/ready handshake with backpressure, a synchronous flush and a per-result overflow flag.
- Serves as the reusable arithmetic delay stage in datapaths where a subtraction result must be aligned with other pipelined signals.

Parameters:
- IN_W, 4: width of aIn and bIn.
- OUT_W, 5: width of subOut; full-precision width is FW = IN_W+1.
- LAT, 3: cycles from input acceptance to result valid; legal range is LAT >= 1.
- SIGNED_IN, 0: 0 means inputs are zero-extended; 1 means inputs are two's-complement and sign-extended.
- SAT, 1: applies only when OUT_W < FW; 1 means clamp, 0 means wrap (truncate).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clr, input, 1: synchronous flush, active high.
- in_valid, input, 1: aIn/bIn hold a valid operand pair.
- in_ready, output, 1: block can accept an operand pair this cycle.
- aIn, input, IN_W: minuend.
- bIn, input, IN_W: subtrahend.
- out_valid, output, 1: subOut/satOut hold a valid result.
- out_ready, input, 1: downstream accepts the result this cycle.
- subOut, output signed, OUT_W: difference.
- satOut, output, 1: the result overflowed OUT_W; clamped if SAT=1, wrapped if SAT=0.

Behaviour:
- Reset: clock is clk; reset rst_n is asynchronous, active-low.
  - While rst_n=0, every stage valid bit, data register and flag register is 0 immediately, without waiting for a clock edge.
  - Hence out_valid=0, subOut=0, satOut=0 and in_ready=0 during reset.
  - in_ready=1 from the first cycle after release.
- Pipeline: LAT register stages.
  - Stage 1 captures the computed, width-converted result and satOut.
  - Stages 2..LAT are pure delays; each stage holds data, flag and a valid bit.
- Advance rule (global stall):
  - adv = !v[LAT] | out_ready.
  - When adv=1, all stages shift one step.
  - When adv=0, all stages hold.
  - in_ready = adv & !clr.
  - Bubbles are not collapsed.
- Acceptance: an input is accepted on a rising edge where in_valid & in_ready.
  - v[1] loads in_valid & in_ready on every advancing edge.
  - A non-accepted cycle inserts a bubble.
- Latency: with out_ready held at 1, the result of an input accepted at edge k appears with out_valid=1 after edge k+LAT-1. It is visible in the LAT-th cycle counted from the acceptance cycle.
- Throughput: 1 result per cycle with no stall.
- Output: out_valid = v[LAT]; subOut and satOut come directly from stage LAT registers, with no combinational path from inputs.
  - A result is consumed on an edge with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, subOut and satOut must stay stable.
- Arithmetic:
  - Extend both operands to FW bits (zero or sign per SIGNED_IN).
  - d = a_ext - b_ext, as FW-bit signed; this never overflows FW.
  - If OUT_W >= FW: subOut = sign-extension of d; satOut = 0.
  - If OUT_W < FW, detect overflow when d > 2^(OUT_W-1)-1 or d < -2^(OUT_W-1):
    - SAT=1: clamp to the respective limit; satOut=1.
    - SAT=0: subOut = d[OUT_W-1:0]; satOut=1.
- clr:
  - On an edge with clr=1, all valid bits clear to 0; data registers may hold stale values.
  - No input is accepted that cycle.
  - clr overrides adv.
- Simultaneous events:
  - Consume at stage LAT and acceptance at stage 1 on the same edge is legal; a full pipe streams at 1/cycle with out_ready=1.
  - clr together with consume: the result is treated as consumed and the pipe empties.
- Reset mid-operation: all in-flight results are discarded; no partial output.

Decomposition:
- Package sub_pipe_pkg holds:
  - function ext_op(value, signed_mode), which returns the FW-bit extension;
  - function fit_out(d, out_w, sat), which returns {sat_flag, result};
  - localparam helpers for FW and the clamp limits.
- One natural sub-module, sub_pipe_stage: a valid+data+flag register with async reset, adv enable and clr. It is instantiated LAT times in a generate loop; stage 1 takes the fit_out output.

Test Plan:
1. Defaults (IN_W=4, OUT_W=5, LAT=3, unsigned), out_ready=1: aIn=3, bIn=7 accepted at edge k -> out_valid=1 after edge k+2, subOut=-4 (5'b11100), satOut=0.
2. Defaults, back-to-back pairs (15,0), (0,15), (9,9) -> subOut 15, -15, 0 on three consecutive cycles, out_valid held at 1.
3. Defaults, stream of 6 pairs with out_ready=0 for 4 cycles once the pipe is full -> in_ready=0 during the stall; subOut stable; all 6 results delivered in order with no loss or duplication.
4. Overflow, OUT_W=4, SAT=1: (15,0) -> 7 with satOut=1; (0,15) -> -8 with satOut=1. Same inputs with SAT=0: (15,0) -> 4'b1111 with satOut=1; (0,15) -> 4'b0001 with satOut=1.
5. Signed inputs, SIGNED_IN=1: aIn=4'b1000 (-8), bIn=4'b0111 (7) -> subOut=-15 (5'b10001); aIn=7, bIn=-8 -> 15.
6. Flush and reset: with 3 results in flight, pulse clr for one cycle -> out_valid=0 next cycle and in_ready=0 during the pulse. Repeat with rst_n low mid-cycle -> out_valid=0, subOut=0 immediately, before any clock edge; after release, (5,2) yields 3 after LAT cycles.
